// File: rtl/riscv_pkg.sv
// Shared core constants: default data width, register-address width, the
// hardwired zero register index and the register reset-value mode.
package riscv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic {
        INIT_ZERO = 1'b0,
        INIT_IDX  = 1'b1
    } init_mode_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: issue sets, either write lane clears, and a
// same-cycle issue beats a clear because it names a newer producer.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter  int unsigned DEPTH = 2**REG_AW,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [1:0]        wr_en,
    input  logic [2*AW-1:0]   wr_addr,
    output logic [DEPTH-1:0]  pending
);

    logic [DEPTH-1:0] pending_r;
    logic [DEPTH-1:0] pending_next_s;
    logic [AW-1:0]    wa0_s;
    logic [AW-1:0]    wa1_s;

    assign wa0_s = wr_addr[0 +: AW];
    assign wa1_s = wr_addr[AW +: AW];

    // next pending vector; register 0 can never be pending
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == int'(ZERO_REG)) begin
                pending_next_s[i] = 1'b0;
            end else if (iss_en && (iss_addr == AW'(i))) begin
                pending_next_s[i] = 1'b1;
            end else if ((wr_en[0] && (wa0_s == AW'(i))) ||
                         (wr_en[1] && (wa1_s == AW'(i)))) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
        end
    end

    // pending state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_r <= {DEPTH{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign pending = pending_r;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_READ read ports, two prioritised write lanes,
// hardwired zero register, optional bypass and registered reads, scoreboard.
module reg_file_mp
    import riscv_pkg::*;
#(
    parameter  int unsigned XLEN       = XLEN_DEF,
    parameter  int unsigned DEPTH      = 2**REG_AW,
    parameter  int unsigned NUM_READ   = 2,
    parameter  int unsigned READ_REG   = 0,
    parameter  int unsigned BYPASS     = 1,
    parameter  int unsigned INIT_INDEX = 1,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_READ*AW-1:0]   rd_addr,
    output logic [NUM_READ*XLEN-1:0] rd_data,
    output logic [NUM_READ-1:0]      rd_busy,
    input  logic [1:0]               wr_en,
    input  logic [2*AW-1:0]          wr_addr,
    input  logic [2*XLEN-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [DEPTH-1:0]         pending
);

    localparam init_mode_e INIT_MODE = (INIT_INDEX != 0) ? INIT_IDX : INIT_ZERO;

    logic [XLEN-1:0] mem_r      [DEPTH];
    logic [XLEN-1:0] mem_next_s [DEPTH];
    logic [AW-1:0]   wa0_s;
    logic [AW-1:0]   wa1_s;
    logic [XLEN-1:0] wd0_s;
    logic [XLEN-1:0] wd1_s;

    assign wa0_s = wr_addr[0 +: AW];
    assign wa1_s = wr_addr[AW +: AW];
    assign wd0_s = wr_data[0 +: XLEN];
    assign wd1_s = wr_data[XLEN +: XLEN];

    // post-edge contents; doubles as the write-first bypass source
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == int'(ZERO_REG)) begin
                mem_next_s[i] = {XLEN{1'b0}};
            end else if (wr_en[1] && (wa1_s == AW'(i))) begin
                mem_next_s[i] = wd1_s;
            end else if (wr_en[0] && (wa0_s == AW'(i))) begin
                mem_next_s[i] = wd0_s;
            end else begin
                mem_next_s[i] = mem_r[i];
            end
        end
    end

    // architectural storage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if ((INIT_MODE == INIT_IDX) && (i != int'(ZERO_REG))) begin
                    mem_r[i] <= XLEN'(i);
                end else begin
                    mem_r[i] <= {XLEN{1'b0}};
                end
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= mem_next_s[i];
            end
        end
    end

    reg_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .pending  (pending)
    );

    for (genvar k = 0; k < int'(NUM_READ); k++) begin : g_rd
        logic [AW-1:0]   ra_s;
        logic [XLEN-1:0] sel_s;

        assign ra_s       = rd_addr[k*AW +: AW];
        assign sel_s      = (BYPASS != 0) ? mem_next_s[ra_s] : mem_r[ra_s];
        assign rd_busy[k] = pending[ra_s];

        if (READ_REG != 0) begin : g_reg
            logic [XLEN-1:0] q_r;

            // registered read port
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    q_r <= {XLEN{1'b0}};
                end else begin
                    q_r <= sel_s;
                end
            end

            assign rd_data[k*XLEN +: XLEN] = q_r;
        end else begin : g_comb
            // comb bypass: mem_next_s equals the enabled lane-1-over-lane-0 write data
            assign rd_data[k*XLEN +: XLEN] = ((BYPASS != 0) && (ra_s != AW'(ZERO_REG)))
                                             ? mem_next_s[ra_s] : mem_r[ra_s];
        end
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port successor to the single-write, dual-read register file, for the pipelined core. It provides NUM_READ read ports, two write ports with a fixed priority, a hardwired zero register, and optional write-to-read bypass. Read data can be combinational or registered. A per-register pending scoreboard lets decode see which source operands still wait on an in-flight producer. It sits between decode (reads, issue) and writeback (two retire lanes).

Parameters:
XLEN, 32, data width in bits
DEPTH, 32, number of architectural registers; power of two, at least 2
NUM_READ, 2, number of read ports, 1..4
READ_REG, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency
BYPASS, 1, 1 = reads see same-cycle writes; 0 = reads see only stored state
INIT_INDEX, 1, 1 = register i resets to value i; 0 = all registers reset to 0
AW, localparam = clog2(DEPTH), address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_addr  in  NUM_READ*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NUM_READ*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
rd_busy  out  NUM_READ  addressed register is pending; always combinational
wr_en  in  2  write enables, one per write lane
wr_addr  in  2*AW  write addresses, one per lane
wr_data  in  2*XLEN  write data, one per lane
iss_en  in  1  mark a destination register as pending
iss_addr  in  AW  destination register being issued
pending  out  DEPTH  scoreboard bit vector; bit i = register i pending

Behaviour:
- Reset (reset = 0), asynchronous:
  - Register i becomes i (INIT_INDEX = 1) or 0 (INIT_INDEX = 0).
  - Register 0 is always 0.
  - pending becomes all zeros.
  - Registered rd_data (READ_REG = 1) becomes 0.
  - Reset takes effect immediately, including mid-operation. The first write is accepted on the first rising edge with reset = 1.
- Register 0:
  - Reads always return 0.
  - Writes to it are dropped.
  - Issue to it is dropped, so pending[0] is always 0 and rd_busy is 0 for address 0.
- Write:
  - On a rising edge, each lane with wr_en set updates its register.
  - If both lanes target the same register, lane 1 wins and lane 0 is discarded.
- Read, READ_REG = 0:
  - rd_data is combinational from rd_addr.
  - With BYPASS = 1, a read address that matches an enabled, nonzero write address returns that write data (lane 1 over lane 0). Otherwise it returns the stored value.
  - With BYPASS = 0, reads return the stored value; new data is visible after the edge.
- Read, READ_REG = 1:
  - rd_data is captured at the rising edge from rd_addr presented in the preceding cycle.
  - With BYPASS = 1, the captured value includes writes committed at that same edge (write-first).
  - With BYPASS = 0, the captured value is the pre-write stored value (read-first).
- Scoreboard:
  - At a rising edge, iss_en sets pending[iss_addr].
  - An enabled write on either lane clears pending[wr_addr].
  - If issue and clear hit the same register in the same cycle, set wins: a new producer supersedes the retiring one.
  - Other bits hold.
- rd_busy[k] = pending[rd_addr_k], with no bypass.
  - Decode stalls on rd_busy; the read data is not valid while busy.
- All indices are treated modulo DEPTH. There are no out-of-range accesses.
- No X propagation from uninitialised storage; every entry is reset.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN default
  - register-address width constant
  - ZERO_REG index constant
  - reset-value-mode enum for INIT_INDEX
- One sub-module, reg_scoreboard: DEPTH pending bits, issue set, dual-lane clear, set-wins priority.
- The storage array, write priority, and per-port read/bypass muxes stay in reg_file_mp, generated over NUM_READ.

Test Plan:
- Reset and init: hold reset = 0 for 3 cycles with INIT_INDEX = 1, release, read addresses 5 and 31 -> rd_data = 5 and 31, pending = 0. Assert reset mid-stream after writing 0xDEAD to reg 7 -> reg 7 reads 7 immediately.
- Register 0: write 0xFFFFFFFF to reg 0 on lane 0 and issue reg 0 -> reads of reg 0 return 0 and rd_busy = 0.
- Dual-write conflict: same edge, lane 0 writes reg 3 = 0x11 and lane 1 writes reg 3 = 0x22 -> reg 3 reads 0x22. Distinct addresses (reg 4 = 0xAA, reg 5 = 0xBB) -> both stored.
- Bypass: READ_REG = 0, BYPASS = 1, write reg 9 = 0x1234 while reading reg 9 -> 0x1234 in the same cycle. With BYPASS = 0 -> old value (9), then 0x1234 next cycle.
- Registered read: READ_REG = 1, address reg 12 while writing 0xCAFE to it at the same edge -> rd_data = 0xCAFE one cycle later (BYPASS = 1) or 12 (BYPASS = 0).
- Scoreboard: issue reg 6 -> pending[6] = 1 and rd_busy high for a port reading reg 6. Lane 1 writes reg 6 -> cleared next cycle. Issue reg 8 while writing reg 8 in the same cycle -> pending[8] stays 1.
